// File: rtl/nv_ram_fifo_ctrl_256x512_if.sv
// Handshake, RAM and status bundle for the 256x512 RAM FIFO controller.
// master = controller side, slave = producer/consumer/RAM side.
interface nv_ram_fifo_ctrl_256x512_if #(
    parameter int AW = 8,
    parameter int DW = 512
);
    logic          wr_pvld;
    logic          wr_prdy;
    logic [DW-1:0] wr_pd;
    logic          rd_pvld;
    logic          rd_prdy;
    logic [DW-1:0] rd_pd;
    logic          ram_we;
    logic [AW-1:0] ram_wa;
    logic [DW-1:0] ram_di;
    logic          ram_re;
    logic [AW-1:0] ram_ra;
    logic [DW-1:0] ram_dout;
    logic [AW+1:0] fifo_count;
    logic          fifo_idle;

    modport master (
        input  wr_pvld, wr_pd, rd_prdy, ram_dout,
        output wr_prdy, rd_pvld, rd_pd, ram_we, ram_wa, ram_di,
               ram_re, ram_ra, fifo_count, fifo_idle
    );

    modport slave (
        output wr_pvld, wr_pd, rd_prdy, ram_dout,
        input  wr_prdy, rd_pvld, rd_pd, ram_we, ram_wa, ram_di,
               ram_re, ram_ra, fifo_count, fifo_idle
    );
endinterface

// File: rtl/nv_ram_fifo_ctrl_256x512.sv
// FIFO controller around a 1-cycle-read 256x512 RAM with a 2-entry output skid
// so reads stream at full rate across the RAM latency.
module nv_ram_fifo_ctrl_256x512 #(
    parameter int AW = 8,
    parameter int DW = 512
) (
    input  logic                               nvdla_core_clk,
    input  logic                               nvdla_core_rstn,
    nv_ram_fifo_ctrl_256x512_if.master         bus
);
    logic [AW-1:0] wr_ptr_q, rd_ptr_q;
    logic [AW:0]   ram_cnt_q, ram_cnt_d, unissued;
    logic          inflight_q;
    logic [1:0]    skid_cnt_q, skid_cnt_d, skid_keep;
    logic [DW-1:0] skid0_q, skid1_q, skid0_d, skid1_d;
    logic [AW+1:0] fifo_count_q, fifo_count_d;
    logic          rdy_en_q;
    logic          wr_prdy, rd_pvld, push, pop, re;
    logic [2:0]    occ, lim;

    // ram_cnt tops out at 2^AW, so the MSB alone flags a full RAM.
    // rdy_en_q holds wr_prdy low through reset and releases it one edge later.
    assign wr_prdy  = rdy_en_q & ~ram_cnt_q[AW];
    assign rd_pvld  = (skid_cnt_q != 2'd0);
    assign push     = bus.wr_pvld & wr_prdy;
    assign pop      = rd_pvld & bus.rd_prdy;
    assign unissued = ram_cnt_q - {{AW{1'b0}}, inflight_q};

    // Issue only if the capture next cycle is guaranteed a free skid slot.
    assign occ = {1'b0, skid_cnt_q} + {2'b00, inflight_q};
    assign lim = 3'd2 + {2'b00, pop};
    assign re  = (unissued != '0) & (occ < lim);

    assign bus.wr_prdy    = wr_prdy;
    assign bus.rd_pvld    = rd_pvld;
    assign bus.rd_pd      = skid0_q;
    assign bus.ram_we     = push;
    assign bus.ram_wa     = wr_ptr_q;
    assign bus.ram_di     = bus.wr_pd;
    assign bus.ram_re     = re;
    assign bus.ram_ra     = rd_ptr_q;
    assign bus.fifo_count = fifo_count_q;
    assign bus.fifo_idle  = (fifo_count_q == '0);

    always_comb begin
        skid0_d   = skid0_q;
        skid1_d   = skid1_q;
        skid_keep = skid_cnt_q - {1'b0, pop};
        if (pop) skid0_d = skid1_q;
        // Returning RAM data lands behind whatever survives this cycle's pop.
        if (inflight_q) begin
            if (skid_keep == 2'd0) skid0_d = bus.ram_dout;
            else                   skid1_d = bus.ram_dout;
        end
        skid_cnt_d   = skid_keep + {1'b0, inflight_q};
        ram_cnt_d    = ram_cnt_q + {{AW{1'b0}}, push} - {{AW{1'b0}}, inflight_q};
        fifo_count_d = {1'b0, ram_cnt_d} + {{AW{1'b0}}, skid_cnt_d};
    end

    always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
        if (!nvdla_core_rstn) begin
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            ram_cnt_q    <= '0;
            inflight_q   <= 1'b0;
            skid_cnt_q   <= '0;
            fifo_count_q <= '0;
            rdy_en_q     <= 1'b0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (re)   rd_ptr_q <= rd_ptr_q + AW'(1);
            ram_cnt_q    <= ram_cnt_d;
            inflight_q   <= re;
            skid_cnt_q   <= skid_cnt_d;
            fifo_count_q <= fifo_count_d;
            rdy_en_q     <= 1'b1;
        end
    end

    // Payload registers are qualified by skid_cnt_q and need no reset.
    always_ff @(posedge nvdla_core_clk) begin
        skid0_q <= skid0_d;
        skid1_q <= skid1_d;
    end
endmodule
